// File: rtl/noc_pkg.sv
// Shared types and helpers for the NoC router input unit: state encoding,
// destination-field width and flit destination-field extraction.
package noc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    REQ   = 2'd2
  } ip_state_t;

  // Widest flit the destination helper accepts.
  localparam int unsigned MAX_FLIT_W = 64;

  function automatic int unsigned dest_w(input int unsigned ports);
    return (ports <= 2) ? 1 : $clog2(ports);
  endfunction

  // Destination field is the top dw bits of a width-bit flit.
  function automatic int unsigned flit_dest(input logic [MAX_FLIT_W-1:0] flit,
                                            input int unsigned           width,
                                            input int unsigned           dw);
    logic [MAX_FLIT_W-1:0] mask;
    mask = (MAX_FLIT_W'(1) << dw) - MAX_FLIT_W'(1);
    return 32'((flit >> (width - dw)) & mask);
  endfunction

endpackage

// File: rtl/noc_fifo.sv
// Show-ahead ring FIFO: rd_data always presents the head entry; an occupancy
// counter separates full from empty so pointers wrap naturally.
module noc_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned FILL_W = PTR_W + 1;
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [FILL_W-1:0] r_fill;
  logic              w_do_wr;
  logic              w_do_rd;

  assign full    = (r_fill == FILL_MAX);
  assign empty   = (r_fill == '0);
  assign w_do_wr = wr_en && !full;
  assign w_do_rd = rd_en && !empty;
  assign rd_data = r_mem[r_rd_ptr];
  assign fill    = r_fill;

  // NOTE: the storage array is deliberately not reset; an empty FIFO never
  // exposes its contents, and leaving it reset-free keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_wr, w_do_rd})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase
    end
  end

endmodule

// File: rtl/noc_input_port.sv
// Router input unit: buffers single-flit packets, decodes the head destination,
// requests the crossbar, pops on grant and raises backpressure upstream.
module noc_input_port
  import noc_pkg::*;
#(
  parameter int unsigned PORTS      = 2,
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned BP_WIDTH   = 1,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_LIM = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [WIDTH-1:0]                  in_data,
  input  logic                              in_valid,
  output logic [BP_WIDTH-1:0]               in_bp,
  output logic [WIDTH-1:0]                  xb_data,
  output logic [dest_w(PORTS)-1:0]          xb_dest,
  output logic                              xb_dest_en,
  input  logic                              xb_ack,
  input  logic [BP_WIDTH-1:0]               xb_bp,
  output logic [$clog2(DEPTH):0]            fill,
  output logic                              overflow,
  output logic                              drop_bad,
  output logic                              starve
);

  localparam int unsigned DEST_W  = dest_w(PORTS);
  localparam int unsigned FILL_W  = $clog2(DEPTH) + 1;
  localparam int unsigned STALL_W = $clog2(STARVE_LIM + 1);
  localparam logic [FILL_W-1:0]  BP_THRESH = FILL_W'(DEPTH - 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STARVE_LIM);

  ip_state_t          r_state;
  ip_state_t          w_state_next;
  logic [WIDTH-1:0]   w_head;
  logic [FILL_W-1:0]  w_fill;
  logic [FILL_W-1:0]  w_fill_next;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_fire;
  logic               w_drop;
  logic               w_req;
  logic               w_head_bad;
  logic [DEST_W-1:0]  w_head_dest;
  logic [STALL_W-1:0] r_stall_cnt;
  logic               r_bp;
  logic               r_overflow;
  logic               r_drop_bad;
  logic               r_starve;

  noc_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_push),
    .wr_data (in_data),
    .rd_en   (w_pop),
    .rd_data (w_head),
    .fill    (w_fill),
    .full    (w_full),
    .empty   (w_empty)
  );

  assign w_head_dest = DEST_W'(flit_dest(MAX_FLIT_W'(w_head), WIDTH, DEST_W));
  assign w_head_bad  = flit_dest(MAX_FLIT_W'(w_head), WIDTH, DEST_W) >= PORTS;

  // A flit arriving while full is lost even if the head leaves this cycle.
  assign w_push      = in_valid && !w_full;
  assign w_req       = (r_state == REQ);
  assign w_fire      = w_req && xb_ack && ~|xb_bp;
  assign w_drop      = (r_state == CHECK) && !w_empty && w_head_bad;
  assign w_pop       = w_fire || w_drop;
  assign w_fill_next = w_fill + FILL_W'(w_push) - FILL_W'(w_pop);

  // NOTE: every always_comb output gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_fill_next != '0) w_state_next = CHECK;
      end
      CHECK: begin
        if (w_empty)         w_state_next = IDLE;
        else if (w_head_bad) w_state_next = (w_fill_next != '0) ? CHECK : IDLE;
        else                 w_state_next = REQ;
      end
      REQ: begin
        if (w_fire) w_state_next = (w_fill_next != '0) ? CHECK : IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_bp        <= 1'b0;
      r_overflow  <= 1'b0;
      r_drop_bad  <= 1'b0;
      r_starve    <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      // One free slot remains when bp rises, absorbing the upstream's reaction delay.
      r_bp <= (w_fill_next >= BP_THRESH);
      if (in_valid && w_full) r_overflow <= 1'b1;
      if (w_drop)             r_drop_bad <= 1'b1;
      if (w_req && !w_fire) begin
        if (r_stall_cnt != STALL_MAX) begin
          r_stall_cnt <= r_stall_cnt + 1'b1;
          if (r_stall_cnt + 1'b1 == STALL_MAX) r_starve <= 1'b1;
        end
      end else begin
        r_stall_cnt <= '0;
      end
    end
  end

  assign in_bp      = {BP_WIDTH{r_bp}};
  assign xb_dest_en = w_req;
  assign xb_data    = w_req ? w_head : '0;
  assign xb_dest    = w_req ? w_head_dest : '0;
  assign fill       = w_fill;
  assign overflow   = r_overflow;
  assign drop_bad   = r_drop_bad;
  assign starve     = r_starve;

endmodule
